// File: rtl/hazard_unit.sv
// ID/EX hazard controller: load-use bubbles, taken-branch squash and memory-wait freeze,
// with saturating stall/flush counters. Control outputs are Mealy on state and inputs.
module hazard_unit #(
  parameter int REG_AW         = 2,
  parameter int LOAD_STALL_CYC = 1,
  parameter int FLUSH_CYC      = 1,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_EX,
  input  logic [REG_AW-1:0] Rd_EX,
  input  logic [REG_AW-1:0] Rs_ID,
  input  logic [REG_AW-1:0] Rt_ID,
  input  logic              Uses_Rs_ID,
  input  logic              Uses_Rt_ID,
  input  logic              Branch_Taken_EX,
  input  logic              Mem_Busy,
  input  logic              Stat_Clear,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Flush,
  output logic              EX_MEM_Write,
  output logic [CNT_W-1:0]  Stall_Count,
  output logic [CNT_W-1:0]  Flush_Count
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, BR_FLUSH, MEM_WAIT} state_t;

  localparam logic [2:0]       LS_INIT  = 3'(LOAD_STALL_CYC - 1);
  localparam logic [2:0]       FL_INIT  = 3'(FLUSH_CYC - 1);
  localparam logic             LS_MULTI = (LOAD_STALL_CYC > 1);
  localparam logic             FL_MULTI = (FLUSH_CYC > 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic lu;
  logic pc_w, ifid_w, ifid_f, idex_f, exmem_w;
  logic stall_inc, flush_inc;

  assign lu = MemRead_EX & ((Uses_Rs_ID & (Rd_EX == Rs_ID)) |
                            (Uses_Rt_ID & (Rd_EX == Rt_ID)));

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    ifid_f    = 1'b0;
    idex_f    = 1'b0;
    exmem_w   = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (Mem_Busy) begin
      // Full freeze; only RUN is parked in MEM_WAIT so it can resume cleanly.
      pc_w      = 1'b0;
      ifid_w    = 1'b0;
      exmem_w   = 1'b0;
      stall_inc = 1'b1;
      if (state_q == RUN) state_d = MEM_WAIT;
    end else if (Branch_Taken_EX) begin
      ifid_f    = 1'b1;
      idex_f    = 1'b1;
      flush_inc = 1'b1;
      if (FL_MULTI) begin
        state_d = BR_FLUSH;
        rem_d   = FL_INIT;
      end else begin
        state_d = RUN;
        rem_d   = 3'd0;
      end
    end else if (state_q == LOAD_STALL) begin
      pc_w      = 1'b0;
      ifid_w    = 1'b0;
      idex_f    = 1'b1;
      stall_inc = 1'b1;
      rem_d     = rem_q - 3'd1;
      if (rem_q == 3'd1) state_d = RUN;
    end else if (state_q == BR_FLUSH) begin
      // IF/ID is being squashed, so a load-use match against it is meaningless.
      ifid_f = 1'b1;
      rem_d  = rem_q - 3'd1;
      if (rem_q == 3'd1) state_d = RUN;
    end else if (lu) begin
      pc_w      = 1'b0;
      ifid_w    = 1'b0;
      idex_f    = 1'b1;
      stall_inc = 1'b1;
      if (LS_MULTI) begin
        state_d = LOAD_STALL;
        rem_d   = LS_INIT;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (Stat_Clear) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall_inc && stall_count_q != CNT_MAX) stall_count_d = stall_count_q + 1'b1;
      if (flush_inc && flush_count_q != CNT_MAX) flush_count_d = flush_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      rem_q         <= 3'd0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  // Reset overrides the pipeline into a held, flushed condition immediately.
  assign PC_Write     = ~rst & pc_w;
  assign IF_ID_Write  = ~rst & ifid_w;
  assign IF_ID_Flush  = rst | ifid_f;
  assign ID_EX_Flush  = rst | idex_f;
  assign EX_MEM_Write = ~rst & exmem_w;
  assign Stall_Count  = stall_count_q;
  assign Flush_Count  = flush_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (3/2 and 1/1 stall/flush lengths) on shared inputs,
// checked against a cycle-count reference model of the hazard rules.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, br_taken, mem_busy, stat_clear, uses_rs, uses_rt;
  logic [1:0] rd_ex, rs_id, rt_id;

  logic       a_pc, a_ifw, a_iff, a_idf, a_exw;
  logic       b_pc, b_ifw, b_iff, b_idf, b_exw;
  logic [7:0] a_sc, a_fc, b_sc, b_fc;
  logic [4:0] obs_ctrl [2];
  logic [7:0] obs_sc [2];
  logic [7:0] obs_fc [2];

  int errors = 0;
  int checks = 0;

  // reference model state, index 0 = instance a, 1 = instance b
  int ls_len [2] = '{3, 1};
  int fl_len [2] = '{2, 1};
  int ls_left [2];
  int fl_left [2];
  int m_sc [2];
  int m_fc [2];

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(2), .LOAD_STALL_CYC(3), .FLUSH_CYC(2), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .MemRead_EX(mem_read), .Rd_EX(rd_ex), .Rs_ID(rs_id), .Rt_ID(rt_id),
    .Uses_Rs_ID(uses_rs), .Uses_Rt_ID(uses_rt), .Branch_Taken_EX(br_taken), .Mem_Busy(mem_busy),
    .Stat_Clear(stat_clear), .PC_Write(a_pc), .IF_ID_Write(a_ifw), .IF_ID_Flush(a_iff),
    .ID_EX_Flush(a_idf), .EX_MEM_Write(a_exw), .Stall_Count(a_sc), .Flush_Count(a_fc));

  hazard_unit #(.REG_AW(2), .LOAD_STALL_CYC(1), .FLUSH_CYC(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .MemRead_EX(mem_read), .Rd_EX(rd_ex), .Rs_ID(rs_id), .Rt_ID(rt_id),
    .Uses_Rs_ID(uses_rs), .Uses_Rt_ID(uses_rt), .Branch_Taken_EX(br_taken), .Mem_Busy(mem_busy),
    .Stat_Clear(stat_clear), .PC_Write(b_pc), .IF_ID_Write(b_ifw), .IF_ID_Flush(b_iff),
    .ID_EX_Flush(b_idf), .EX_MEM_Write(b_exw), .Stall_Count(b_sc), .Flush_Count(b_fc));

  assign obs_ctrl[0] = {a_pc, a_ifw, a_iff, a_idf, a_exw};
  assign obs_ctrl[1] = {b_pc, b_ifw, b_iff, b_idf, b_exw};
  assign obs_sc[0] = a_sc;
  assign obs_sc[1] = b_sc;
  assign obs_fc[0] = a_fc;
  assign obs_fc[1] = b_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ls_left[i] = 0;
      fl_left[i] = 0;
      m_sc[i] = 0;
      m_fc[i] = 0;
    end
  endtask

  // ctrl vector order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Write}
  task automatic model_step(input int i, output logic [4:0] exp);
    logic lu;
    bit stalled, flushed;
    lu = mem_read && ((uses_rs && rd_ex == rs_id) || (uses_rt && rd_ex == rt_id));
    stalled = 0;
    flushed = 0;
    if (mem_busy) begin
      exp = 5'b00000;
      stalled = 1;
    end else if (br_taken) begin
      exp = 5'b11111;
      flushed = 1;
      ls_left[i] = 0;
      fl_left[i] = fl_len[i] - 1;
    end else if (ls_left[i] > 0) begin
      exp = 5'b00011;
      stalled = 1;
      ls_left[i]--;
    end else if (fl_left[i] > 0) begin
      exp = 5'b11101;
      fl_left[i]--;
    end else if (lu) begin
      exp = 5'b00011;
      stalled = 1;
      ls_left[i] = ls_len[i] - 1;
    end else begin
      exp = 5'b11001;
    end
    if (stat_clear) begin
      m_sc[i] = 0;
      m_fc[i] = 0;
    end else begin
      if (stalled && m_sc[i] < 255) m_sc[i]++;
      if (flushed && m_fc[i] < 255) m_fc[i]++;
    end
  endtask

  task automatic step(input logic busy, input logic br, input logic mr, input logic [1:0] rd,
                      input logic [1:0] rs, input logic [1:0] rt, input logic urs,
                      input logic urt, input logic clr);
    logic [4:0] exp;
    @(negedge clk);
    mem_busy = busy; br_taken = br; mem_read = mr; rd_ex = rd; rs_id = rs; rt_id = rt;
    uses_rs = urs; uses_rt = urt; stat_clear = clr;
    #1;
    for (int i = 0; i < 2; i++) begin
      model_step(i, exp);
      chk($sformatf("ctrl[%0d]", i), 32'(obs_ctrl[i]), 32'(exp));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("stall_cnt[%0d]", i), 32'(obs_sc[i]), 32'(m_sc[i]));
      chk($sformatf("flush_cnt[%0d]", i), 32'(obs_fc[i]), 32'(m_fc[i]));
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 2'd0, 2'd1, 2'd2, 0, 0, 0);
  endtask

  task automatic load_use();
    step(0, 0, 1, 2'd2, 2'd2, 2'd0, 1, 0, 0);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ctrl[%0d]", tag, i), 32'(obs_ctrl[i]), 32'(5'b00110));
      chk($sformatf("%s_stall[%0d]", tag, i), 32'(obs_sc[i]), 32'd0);
      chk($sformatf("%s_flush[%0d]", tag, i), 32'(obs_fc[i]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 0; br_taken = 0; mem_busy = 0; stat_clear = 0; uses_rs = 0; uses_rt = 0;
    rd_ex = 0; rs_id = 0; rt_id = 0;
    model_reset();
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
    idle();

    // single load-use, then let each instance run out its bubbles
    load_use();
    repeat (3) idle();

    // branch wins over a simultaneous load-use
    step(0, 1, 1, 2'd2, 2'd2, 2'd0, 1, 0, 0);
    repeat (2) idle();

    // memory wait lands on the second cycle of a load stall
    load_use();
    repeat (4) step(1, 0, 1, 2'd2, 2'd2, 2'd0, 1, 0, 0);
    repeat (3) idle();

    // Rt matches but is not read: no stall
    step(0, 0, 1, 2'd1, 2'd0, 2'd1, 0, 0, 0);
    step(0, 0, 1, 2'd1, 2'd3, 2'd1, 1, 0, 0);

    // saturation, then a clear that coincides with a stall
    step(0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 1);
    repeat (300) load_use();
    chk("stall_sat_a", 32'(a_sc), 32'd255);
    chk("stall_sat_b", 32'(b_sc), 32'd255);
    step(0, 0, 1, 2'd2, 2'd2, 2'd0, 1, 0, 1);
    repeat (3) idle();

    // asynchronous reset in the middle of a load stall
    step(0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    idle();
    load_use();
    @(negedge clk);
    mem_read = 0; uses_rs = 0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    idle();
    load_use();

    // randomized traffic
    repeat (500) begin
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
